vga_display_ctrl: RTL and testbench

//  640x480@60Hz VGA timing generator and pixel output stage for the snake game display.

---
 rtl/vga_display_ctrl.sv | 88 ++++++++
 tb/tb_vga_display_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_display_ctrl.sv
// 640x480@60Hz VGA timing generator and pixel output stage, one pixel per 25 MHz clock.
// Counters sweep the full frame; sync, address and read strobe are registered from them.
module vga_display_ctrl #(
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] Din,
    output logic [8:0]  row,
    output logic [9:0]  col,
    output logic        rdn,
    output logic [3:0]  R,
    output logic [3:0]  G,
    output logic [3:0]  B,
    output logic        HS,
    output logic        VS
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
    localparam logic [9:0] H_START     = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_STOP      = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0] V_START     = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_STOP      = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [8:0] V_START_ROW = 9'(V_SYNC + V_BP);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_wrap;
    logic       visible;

    assign h_wrap  = (h_cnt == H_LAST);
    assign visible = (h_cnt >= H_START) && (h_cnt <= H_STOP) &&
                     (v_cnt >= V_START) && (v_cnt <= V_STOP);

    // Line counter advances only on the last pixel of a line, so both wrap together at frame end.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            if (h_wrap) begin
                h_cnt <= '0;
                if (v_cnt == V_LAST) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + 10'd1;
                end
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Outputs lag the counters by one cycle; row/col are plain differences and only meaningful while rdn=0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            HS  <= 1'b0;
            VS  <= 1'b0;
            rdn <= 1'b1;
            row <= '0;
            col <= '0;
        end else begin
            HS  <= (h_cnt >= H_SYNC_END);
            VS  <= (v_cnt >= V_SYNC_END);
            rdn <= ~visible;
            col <= h_cnt - H_START;
            row <= v_cnt[8:0] - V_START_ROW;
        end
    end

    assign R = rdn ? 4'h0 : Din[11:8];
    assign G = rdn ? 4'h0 : Din[7:4];
    assign B = rdn ? 4'h0 : Din[3:0];

endmodule

// File: tb/tb_vga_display_ctrl.sv
// Self-checking bench: a full-size DUT plus a shrunken-timing DUT so that frame wrap fits in a short run.
module tb_vga_display_ctrl;

    localparam int S_HSY = 8, S_HBP = 4, S_HAC = 16, S_HFP = 4;
    localparam int S_VSY = 2, S_VBP = 3, S_VAC = 6, S_VFP = 2;
    localparam int S_FRAME = (S_HSY + S_HBP + S_HAC + S_HFP) * (S_VSY + S_VBP + S_VAC + S_VFP);

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       rdn;
        logic [8:0] row;
        logic [9:0] col;
    } vga_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] din = 12'h0F0;
    logic        rand_din = 1'b0;

    logic [8:0] row, s_row;
    logic [9:0] col, s_col;
    logic       rdn, s_rdn, hs, s_hs, vs, s_vs;
    logic [3:0] r, g, b, s_r, s_g, s_b;

    int checks = 0;
    int passed = 0;
    int edges  = 0;

    vga_display_ctrl dut (
        .clk(clk), .rst(rst), .Din(din), .row(row), .col(col), .rdn(rdn),
        .R(r), .G(g), .B(b), .HS(hs), .VS(vs)
    );

    vga_display_ctrl #(
        .H_SYNC(S_HSY), .H_BP(S_HBP), .H_ACTIVE(S_HAC), .H_FP(S_HFP),
        .V_SYNC(S_VSY), .V_BP(S_VBP), .V_ACTIVE(S_VAC), .V_FP(S_VFP)
    ) small_dut (
        .clk(clk), .rst(rst), .Din(din), .row(s_row), .col(s_col), .rdn(s_rdn),
        .R(s_r), .G(s_g), .B(s_b), .HS(s_hs), .VS(s_vs)
    );

    always #20 clk = ~clk;

    // Expected outputs at absolute pixel position p of the frame sweep, from the timing rules alone.
    function automatic vga_t model(input int p, input int hsy, hbp, hac, hfp, vsy, vbp, vac, vfp);
        vga_t m;
        int ht, vt, h, v, hst, vst;
        ht  = hsy + hbp + hac + hfp;
        vt  = vsy + vbp + vac + vfp;
        h   = p % ht;
        v   = (p / ht) % vt;
        hst = hsy + hbp;
        vst = vsy + vbp;
        m.hs  = (h >= hsy);
        m.vs  = (v >= vsy);
        m.rdn = !(h >= hst && h < hst + hac && v >= vst && v < vst + vac);
        m.col = 10'(h - hst);
        m.row = 9'(v - vst);
        return m;
    endfunction

    function automatic vga_t model_full(input int p);
        return model(p, 96, 48, 640, 16, 2, 33, 480, 10);
    endfunction

    function automatic vga_t model_small(input int p);
        return model(p, S_HSY, S_HBP, S_HAC, S_HFP, S_VSY, S_VBP, S_VAC, S_VFP);
    endfunction

    // Edge k after reset release registers the counters at position k-1.
    task automatic tick();
        @(posedge clk);
        if (rst) edges++;
        #1;
        if (rand_din) din = 12'($urandom);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int n;
        rand_din = 1'b0;
        din = 12'h0F0;
        rst = 1'b0;
        #90;
        checks++;
        if ({hs, vs, rdn, row, col, r, g, b} !== {1'b0, 1'b0, 1'b1, 9'd0, 10'd0, 12'h000})
            $display("[TB] FAIL reset_full got hs=%b vs=%b rdn=%b row=%0d col=%0d rgb=%h", hs, vs, rdn, row, col, {r, g, b});
        else passed++;
        checks++;
        if ({s_hs, s_vs, s_rdn, s_row, s_col, s_r, s_g, s_b} !== {1'b0, 1'b0, 1'b1, 9'd0, 10'd0, 12'h000})
            $display("[TB] FAIL reset_small got hs=%b vs=%b rdn=%b row=%0d col=%0d rgb=%h", s_hs, s_vs, s_rdn, s_row, s_col, {s_r, s_g, s_b});
        else passed++;
        @(negedge clk);
        rst = 1'b1;
        edges = 0;
        n = 0;
        while (hs !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (hs !== 1'b1 || edges != 97)
            $display("[TB] FAIL first_hs_rise got edge %0d (hs=%b) required edge 97", edges, hs);
        else passed++;
    endtask

    task automatic test_free_run(input int cycles);
        vga_t e;
        logic prev_hs, prev_vs, prev_rdn;
        logic [9:0] prev_col;
        int last_rise, last_fall, low_run;
        rand_din  = 1'b1;
        prev_hs   = hs;
        prev_vs   = vs;
        prev_rdn  = rdn;
        prev_col  = col;
        last_rise = edges;
        last_fall = -1;
        low_run   = 0;
        for (int k = 0; k < cycles; k++) begin
            tick();
            e = model_full(edges - 1);
            checks++;
            if ({hs, vs, rdn, row, col} !== e)
                $display("[TB] FAIL timing p=%0d got hs=%b vs=%b rdn=%b row=%0d col=%0d required hs=%b vs=%b rdn=%b row=%0d col=%0d",
                         edges - 1, hs, vs, rdn, row, col, e.hs, e.vs, e.rdn, e.row, e.col);
            else passed++;
            checks++;
            if ({r, g, b} !== (e.rdn ? 12'h000 : din))
                $display("[TB] FAIL colour p=%0d got %h required %h", edges - 1, {r, g, b}, e.rdn ? 12'h000 : din);
            else passed++;
            if (!prev_hs && hs) begin
                checks++;
                if (edges - last_rise != 800 || edges - last_fall != 96)
                    $display("[TB] FAIL hs_period got period %0d low %0d required 800/96", edges - last_rise, edges - last_fall);
                else passed++;
                last_rise = edges;
            end
            if (prev_hs && !hs) last_fall = edges;
            if (!prev_vs && vs) begin
                checks++;
                if (edges != 1601)
                    $display("[TB] FAIL vs_rise got edge %0d required 1601", edges);
                else passed++;
            end
            if (prev_rdn && !rdn) begin
                checks++;
                if (col !== 10'd0)
                    $display("[TB] FAIL rdn_fall_col got %0d required 0", col);
                else passed++;
            end
            if (!prev_rdn && rdn) begin
                checks++;
                if (prev_col !== 10'd639 || low_run != 640)
                    $display("[TB] FAIL rdn_line got last col %0d run %0d required 639/640", prev_col, low_run);
                else passed++;
            end
            low_run  = rdn ? 0 : low_run + 1;
            prev_hs  = hs;
            prev_vs  = vs;
            prev_rdn = rdn;
            prev_col = col;
        end
    endtask

    task automatic test_colour(input int cycles);
        vga_t e;
        rand_din = 1'b0;
        din = 12'h0F0;
        for (int k = 0; k < cycles; k++) begin
            tick();
            e = model_full(edges - 1);
            checks++;
            if ({r, g, b} !== (e.rdn ? 12'h000 : 12'h0F0))
                $display("[TB] FAIL colour_0f0 p=%0d got %h required %h", edges - 1, {r, g, b}, e.rdn ? 12'h000 : 12'h0F0);
            else passed++;
        end
    endtask

    task automatic test_mid_reset();
        vga_t e;
        int target, n;
        target = 40 * 800 + 444 + 1;
        rand_din = 1'b1;
        n = 0;
        while (edges < target && n < 40000) begin
            tick();
            n++;
        end
        checks++;
        if (edges != target || rdn !== 1'b0 || col !== 10'd300)
            $display("[TB] FAIL mid_line_reach got edge %0d rdn=%b col=%0d required edge %0d rdn=0 col=300", edges, rdn, col, target);
        else passed++;
        #5;
        rst = 1'b0;
        #1;
        checks++;
        if ({hs, vs, rdn, row, col, r, g, b} !== {1'b0, 1'b0, 1'b1, 9'd0, 10'd0, 12'h000})
            $display("[TB] FAIL async_reset got hs=%b vs=%b rdn=%b row=%0d col=%0d rgb=%h", hs, vs, rdn, row, col, {r, g, b});
        else passed++;
        edges = 0;
        tick();
        tick();
        checks++;
        if ({hs, vs, rdn, s_hs, s_vs, s_rdn} !== 6'b001001)
            $display("[TB] FAIL reset_hold got %b required 001001", {hs, vs, rdn, s_hs, s_vs, s_rdn});
        else passed++;
        rst = 1'b1;
        for (int k = 0; k < 900; k++) begin
            tick();
            e = model_full(edges - 1);
            checks++;
            if ({hs, vs, rdn, row, col} !== e)
                $display("[TB] FAIL restart p=%0d got hs=%b vs=%b rdn=%b col=%0d required hs=%b vs=%b rdn=%b col=%0d",
                         edges - 1, hs, vs, rdn, col, e.hs, e.vs, e.rdn, e.col);
            else passed++;
        end
    endtask

    task automatic test_frame_wrap();
        vga_t e;
        vga_t rec [S_FRAME];
        int p, f0;
        rand_din = 1'b1;
        f0 = (edges / S_FRAME) + 1;
        for (int k = 0; k < 3 * S_FRAME; k++) begin
            tick();
            p = edges - 1;
            e = model_small(p);
            checks++;
            if ({s_hs, s_vs, s_rdn, s_row, s_col} !== e)
                $display("[TB] FAIL small_timing p=%0d got hs=%b vs=%b rdn=%b row=%0d col=%0d required hs=%b vs=%b rdn=%b row=%0d col=%0d",
                         p, s_hs, s_vs, s_rdn, s_row, s_col, e.hs, e.vs, e.rdn, e.row, e.col);
            else passed++;
            checks++;
            if ({s_r, s_g, s_b} !== (e.rdn ? 12'h000 : din))
                $display("[TB] FAIL small_colour p=%0d got %h required %h", p, {s_r, s_g, s_b}, e.rdn ? 12'h000 : din);
            else passed++;
            if (p / S_FRAME == f0) rec[p % S_FRAME] = {s_hs, s_vs, s_rdn, s_row, s_col};
            if (p / S_FRAME == f0 + 1) begin
                checks++;
                if ({s_hs, s_vs, s_rdn, s_row, s_col} !== rec[p % S_FRAME])
                    $display("[TB] FAIL frame_repeat pos=%0d got %h required %h", p % S_FRAME,
                             {s_hs, s_vs, s_rdn, s_row, s_col}, rec[p % S_FRAME]);
                else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_free_run(30000);
        test_colour(1600);
        test_mid_reset();
        test_frame_wrap();
        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
